// File: rtl/display_pkg.sv
// display_pkg: shared constants for the display timing generator and the
// paint stages downstream of it.
//   CORDW            coordinate width in bits (holds H_TOTAL-1 and V_TOTAL-1)
//   *_480P           default 640x480 @ 60 Hz timing, in pixels / lines
//   SYNC_ACTIVE_*    sync polarity selectors
//   coord_t          screen coordinate type
package display_pkg;

  localparam int CORDW = 10;

  localparam int H_ACTIVE_480P = 640;
  localparam int H_FP_480P     = 16;
  localparam int H_SYNC_480P   = 96;
  localparam int H_BP_480P     = 48;

  localparam int V_ACTIVE_480P = 480;
  localparam int V_FP_480P     = 10;
  localparam int V_SYNC_480P   = 2;
  localparam int V_BP_480P     = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  typedef logic [CORDW-1:0] coord_t;

endpackage

// File: rtl/display_timing_480p.sv
// display_timing_480p: pixel-clock raster timing generator (640x480 @ 60 Hz
// by default).
// Ports:
//   clk_pix  in   pixel clock, the only clock
//   rst_pix  in   synchronous active-high reset
//   sx, sy   out  current screen position
//   hsync    out  horizontal sync, at H_POL when active
//   vsync    out  vertical sync, at V_POL when active
//   de       out  data enable, high in the active area
//   frame    out  one-cycle strobe at (0,0)
//   line     out  one-cycle strobe at sx == 0 on every line
// All outputs are flops. Each is loaded from the *next* position, so in any
// cycle every output describes the same (sx, sy).
module display_timing_480p
  import display_pkg::*;
#(
  parameter int   CORDW    = display_pkg::CORDW,
  parameter int   H_ACTIVE = H_ACTIVE_480P,
  parameter int   H_FP     = H_FP_480P,
  parameter int   H_SYNC   = H_SYNC_480P,
  parameter int   H_BP     = H_BP_480P,
  parameter int   V_ACTIVE = V_ACTIVE_480P,
  parameter int   V_FP     = V_FP_480P,
  parameter int   V_SYNC   = V_SYNC_480P,
  parameter int   V_BP     = V_BP_480P,
  parameter logic H_POL    = SYNC_ACTIVE_LOW,
  parameter logic V_POL    = SYNC_ACTIVE_LOW
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame,
  output logic             line
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST    = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST    = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT_END = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] V_ACT_END = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_FIRST  = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_LAST   = CORDW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_FIRST  = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_LAST   = CORDW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CORDW-1:0] ZERO      = CORDW'(0);
  localparam logic [CORDW-1:0] ONE       = CORDW'(1);

  logic [CORDW-1:0] sx_q, sx_d;
  logic [CORDW-1:0] sy_q, sy_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic de_q, de_d;
  logic frame_q, frame_d;
  logic line_q, line_d;

  // Next raster position; wraps are explicit compares, never overflow.
  always_comb begin
    sx_d = sx_q + ONE;
    sy_d = sy_q;
    if (sx_q == H_LAST) begin
      sx_d = ZERO;
      if (sy_q == V_LAST) begin
        sy_d = ZERO;
      end else begin
        sy_d = sy_q + ONE;
      end
    end else begin
      sy_d = sy_q;
    end
  end

  // Decode the next position so the registered strobes line up with sx/sy.
  always_comb begin
    de_d    = (sx_d < H_ACT_END) && (sy_d < V_ACT_END);
    hsync_d = ((sx_d >= HS_FIRST) && (sx_d <= HS_LAST)) ? H_POL : ~H_POL;
    vsync_d = ((sy_d >= VS_FIRST) && (sy_d <= VS_LAST)) ? V_POL : ~V_POL;
    line_d  = (sx_d == ZERO);
    frame_d = (sx_d == ZERO) && (sy_d == ZERO);
  end

  // Position and output registers; reset parks on the last pixel of the frame
  // so the first cycle after release presents (0,0).
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sx_q    <= H_LAST;
      sy_q    <= V_LAST;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
      frame_q <= 1'b0;
      line_q  <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      frame_q <= frame_d;
      line_q  <= line_d;
    end
  end

  assign sx    = sx_q;
  assign sy    = sy_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign frame = frame_q;
  assign line  = line_q;

endmodule

// File: tb/tb_display_timing_480p.sv
// Bench for display_timing_480p: a default 480p instance (A) with directed
// boundary checks, and a tiny-raster instance (B, active-high hsync) with
// random reset pulses. Both are compared every cycle with a reference model
// that derives the position from the cycle count since reset release.
module tb_display_timing_480p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic [9:0] a_sx, a_sy, b_sx, b_sy;
  logic a_hs, a_vs, a_de, a_fr, a_ln;
  logic b_hs, b_vs, b_de, b_fr, b_ln;

  display_timing_480p dut_a (
    .clk_pix(clk), .rst_pix(rst_a),
    .sx(a_sx), .sy(a_sy), .hsync(a_hs), .vsync(a_vs),
    .de(a_de), .frame(a_fr), .line(a_ln)
  );

  // B: H_TOTAL = 17, V_TOTAL = 13, frame = 221 cycles
  display_timing_480p #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b1), .V_POL(1'b0)
  ) dut_b (
    .clk_pix(clk), .rst_pix(rst_b),
    .sx(b_sx), .sy(b_sy), .hsync(b_hs), .vsync(b_vs),
    .de(b_de), .frame(b_fr), .line(b_ln)
  );

  int n_a = -1;
  int n_b = -1;
  int total = 0;
  int passed = 0;
  int failed = 0;
  bit b_rand = 1'b0;
  bit b_cnt = 1'b0;
  int cnt_fr = 0, cnt_ln = 0, cnt_de = 0, cnt_vs = 0, cnt_devs = 0;

  // Expected {sx, sy, hsync, vsync, de, frame, line} for n cycles after
  // release (n < 0: still in reset).
  function automatic logic [24:0] ref_out(input int n,
      input int ha, input int hfp, input int hsw, input int hbp,
      input int va, input int vfp, input int vsw, input int vbp,
      input logic hpol, input logic vpol);
    int ht, vt, x, y;
    logic hs, vs, de, fr, ln;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (n < 0) return {10'(ht - 1), 10'(vt - 1), ~hpol, ~vpol, 3'b000};
    x  = n % ht;
    y  = (n / ht) % vt;
    hs = (x >= ha + hfp && x < ha + hfp + hsw) ? hpol : ~hpol;
    vs = (y >= va + vfp && y < va + vfp + vsw) ? vpol : ~vpol;
    de = (x < ha) && (y < va);
    fr = (x == 0) && (y == 0);
    ln = (x == 0);
    return {10'(x), 10'(y), hs, vs, de, fr, ln};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance models from the sampled resets, check both DUTs.
  task automatic step();
    @(posedge clk);
    n_a = rst_a ? -1 : n_a + 1;
    n_b = rst_b ? -1 : n_b + 1;
    #1;
    chk("a_model", {7'd0, a_sx, a_sy, a_hs, a_vs, a_de, a_fr, a_ln},
        {7'd0, ref_out(n_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0)});
    chk("b_model", {7'd0, b_sx, b_sy, b_hs, b_vs, b_de, b_fr, b_ln},
        {7'd0, ref_out(n_b, 8, 2, 3, 4, 6, 2, 2, 3, 1'b1, 1'b0)});
    if (b_cnt) begin
      cnt_fr += int'(b_fr);
      cnt_ln += int'(b_ln);
      cnt_de += int'(b_de);
      cnt_vs += int'(!b_vs);
      cnt_devs += int'(b_de && !b_vs);
    end
    if (b_rand) rst_b = ($urandom_range(0, 399) == 0);
  endtask

  task automatic run_a_to(input int x, input int y);
    while (n_a < y * 800 + x) step();
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, "_sx"}, 32'(a_sx), 32'd799);
    chk({tag, "_sy"}, 32'(a_sy), 32'd524);
    chk({tag, "_de"}, 32'(a_de), 32'd0);
    chk({tag, "_hs"}, 32'(a_hs), 32'd1);
    chk({tag, "_vs"}, 32'(a_vs), 32'd1);
    chk({tag, "_frame"}, 32'(a_fr), 32'd0);
    chk({tag, "_line"}, 32'(a_ln), 32'd0);
  endtask

  initial begin
    int hs_low, de_in_hs, x;

    // Reset held for several cycles
    repeat (3) begin
      step();
      chk_a_reset("rst");
    end

    // Release: first cycle is (0,0)
    rst_a = 1'b0;
    rst_b = 1'b0;
    step();
    chk("rel_sx", 32'(a_sx), 32'd0);
    chk("rel_sy", 32'(a_sy), 32'd0);
    chk("rel_de", 32'(a_de), 32'd1);
    chk("rel_frame", 32'(a_fr), 32'd1);
    chk("rel_line", 32'(a_ln), 32'd1);
    b_rand = 1'b1;

    // Active/blanking boundary on line 0
    run_a_to(639, 0);
    chk("de_639", 32'(a_de), 32'd1);
    step();
    chk("sx_640", 32'(a_sx), 32'd640);
    chk("de_640", 32'(a_de), 32'd0);

    // Hsync window across the rest of line 0
    hs_low = 0;
    de_in_hs = 0;
    while (n_a < 799) begin
      step();
      x = n_a % 800;
      hs_low += int'(!a_hs);
      de_in_hs += int'(!a_hs && a_de);
      if (x == 655) chk("hs_655", 32'(a_hs), 32'd1);
      if (x == 656) chk("hs_656", 32'(a_hs), 32'd0);
      if (x == 751) chk("hs_751", 32'(a_hs), 32'd0);
      if (x == 752) chk("hs_752", 32'(a_hs), 32'd1);
    end
    chk("hs_low_cycles", 32'(hs_low), 32'd96);
    chk("de_during_hs", 32'(de_in_hs), 32'd0);

    // Line wrap into a blanking-free line
    run_a_to(799, 5);
    step();
    chk("wrap_sx", 32'(a_sx), 32'd0);
    chk("wrap_sy", 32'(a_sy), 32'd6);
    chk("wrap_line", 32'(a_ln), 32'd1);
    chk("wrap_frame", 32'(a_fr), 32'd0);

    // B: two clean frames, counted
    b_rand = 1'b0;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    b_cnt = 1'b1;
    repeat (442) step();
    b_cnt = 1'b0;
    chk("b_frames", 32'(cnt_fr), 32'd2);
    chk("b_lines", 32'(cnt_ln), 32'd26);
    chk("b_de", 32'(cnt_de), 32'd96);
    chk("b_vs_low", 32'(cnt_vs), 32'd68);
    chk("b_de_in_vs", 32'(cnt_devs), 32'd0);
    chk("b_last_sx", 32'(b_sx), 32'd16);
    chk("b_last_sy", 32'(b_sy), 32'd12);
    step();
    chk("b_fwrap_sx", 32'(b_sx), 32'd0);
    chk("b_fwrap_sy", 32'(b_sy), 32'd0);
    chk("b_fwrap_frame", 32'(b_fr), 32'd1);
    b_rand = 1'b1;

    // Mid-frame reset on A
    run_a_to(123, 77);
    chk("mid_sx", 32'(a_sx), 32'd123);
    chk("mid_sy", 32'(a_sy), 32'd77);
    rst_a = 1'b1;
    repeat (3) begin
      step();
      chk_a_reset("mid_rst");
    end
    rst_a = 1'b0;
    step();
    chk("restart_sx", 32'(a_sx), 32'd0);
    chk("restart_sy", 32'(a_sy), 32'd0);
    chk("restart_frame", 32'(a_fr), 32'd1);
    repeat (1700) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/display_timing_480p.md
# display_timing_480p

Pixel-clock display timing generator for 640x480 at 60 Hz (25.2 MHz nominal pixel clock). It produces the screen coordinates `sx`/`sy` consumed by the paint stages, plus sync, data-enable and frame/line strobes for the DVI/VGA output stage. It sits directly upstream of every painter, which takes `sx`/`sy` combinationally and returns a 4-bit-per-channel colour.

## Interface
- `CORDW`, 10: coordinate width in bits; must hold `H_TOTAL-1` and `V_TOTAL-1`.
- `H_ACTIVE`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: active lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `H_POL`, 0: hsync active level (0 = active-low).
- `V_POL`, 0: vsync active level (0 = active-low).

Ports:
- `clk_pix`  in  1: pixel clock; the only clock.
- `rst_pix`  in  1: synchronous, active-high reset.
- `sx`  out  CORDW: horizontal position, 0..`H_TOTAL-1`.
- `sy`  out  CORDW: vertical position, 0..`V_TOTAL-1`.
- `hsync`  out  1: horizontal sync, at the `H_POL` level when active.
- `vsync`  out  1: vertical sync, at the `V_POL` level when active.
- `de`  out  1: data enable; high in the active area.
- `frame`  out  1: one-cycle strobe at (0,0).
- `line`  out  1: one-cycle strobe when `sx`=0, on every line including blanking lines.

## Operation
- Derived values: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (800); `V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP` (525).
- Raster order:
  - `sx` increments each cycle.
  - When `sx` = `H_TOTAL-1`, `sx` wraps to 0 and `sy` increments.
  - When `sy` = `V_TOTAL-1` at a line wrap, `sy` wraps to 0.
  - There are no other `sy` transitions.
- Decodes, all evaluated at the position being presented:
  - `de` = (`sx` < `H_ACTIVE`) && (`sy` < `V_ACTIVE`).
  - hsync is active for `sx` in [`H_ACTIVE+H_FP`, `H_ACTIVE+H_FP+H_SYNC-1`], i.e. 656..751.
  - vsync is active for `sy` in [`V_ACTIVE+V_FP`, `V_ACTIVE+V_FP+V_SYNC-1`], i.e. 490..491.
  - vsync depends only on `sy`; it changes on the `sx`=0 boundary.
  - `line` = (`sx` == 0).
  - `frame` = (`sx` == 0 && `sy` == 0).
- Counter arithmetic is unsigned CORDW-bit. Wraps are explicit compares against `*_TOTAL-1`, never natural overflow. Counter values outside the legal range cannot occur.

## Timing
- Every output is a flip-flop, with no combinational path from any input to any output.
- The output registers are computed from the next counter position, so all outputs in a given cycle describe the same (`sx`,`sy`). A downstream painter therefore sees colour, `de` and syncs aligned without extra delay.
- Reset state: the last position of the frame.
  - `sx`=`H_TOTAL-1` (799), `sy`=`V_TOTAL-1` (524).
  - `de`=0.
  - hsync and vsync inactive (`!H_POL`, `!V_POL`).
  - `frame`=0, `line`=0.
  - This state holds for every cycle `rst_pix` is sampled high.
- First cycle after reset release: (0,0), with `de`=1, `frame`=1, `line`=1.
- Reset asserted mid-frame: the block returns to the reset state on the next edge. No partial line or frame completes; downstream must not expect one.
- Period: one line every `H_TOTAL` cycles; one frame every `H_TOTAL*V_TOTAL` cycles (420000).
- `frame` and `line` are high for exactly one cycle. `frame` always coincides with a `line` pulse.

## Structure
- Shared package `display_pkg`:
  - `CORDW`.
  - The default 480p timing constants.
  - Polarity constants `SYNC_ACTIVE_LOW`/`SYNC_ACTIVE_HIGH`.
  - A typedef for the coordinate type `coord_t` (logic [CORDW-1:0]).
- Single module; no sub-module. The horizontal and vertical counters are small enough to be inline always_ff blocks.
- Derived totals and sync bounds are localparams computed from the parameters.

## Test plan
- Reset then release: while reset is high, (799,524), `de`=0, hsync=1, vsync=1, `frame`=0. On the first cycle after release, (0,0) with `de`=`frame`=`line`=1.
- Line boundary: at (639,0), `de`=1; at (640,0), `de`=0. From (799,5), the next cycle is (0,6) with `line`=1 and `frame`=0.
- Hsync window: hsync=1 at `sx`=655; 0 at 656 through 751; 1 at 752. Exactly 96 low cycles per line; `de`=0 throughout.
- Frame wrap: from (799,524), the next cycle is (0,0) with `frame`=1. Over 420000 cycles, count exactly 1 `frame`, 525 `line` and 307200 `de` cycles.
- Vsync window: vsync goes low at (0,490) and returns high at (0,492), giving 1600 low cycles. `de` is never high during vsync.
- Mid-frame reset: pulse `rst_pix` for 3 cycles at (123,77). Outputs go to the reset state on the next edge and hold it. Counting restarts from (0,0), and `frame` is asserted after release.
